// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/ack channel between fetch and imem
interface fetch_stage_if;
  logic ImemReq;
  logic [31:0] ImemAddr;
  logic ImemAck;
  logic [31:0] ImemRData;
  modport master(output ImemReq, ImemAddr, input ImemAck, ImemRData);
  modport slave(input ImemReq, ImemAddr, output ImemAck, ImemRData);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, imem request/ack, one-entry skid and squash on redirect
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Redirect,
  input  logic [1:0] PCSrc,
  input  logic [31:0] TargetBase,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic Stall,
  fetch_stage_if.master imem,
  output logic InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4
);
  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
  state_t state, next_state;
  logic [31:0] pc, req_addr, skid_instr, skid_pc, target, next_pc;
  logic squash, ack, take, slot_free, start;
  assign ack = state == FETCH && imem.ImemAck;
  assign take = ack && !squash && !Redirect;
  assign slot_free = !InstrValid || !Stall;
  assign target = PCSrc == 2'b00 ? pc + 32'd4 :
                  PCSrc == 2'b01 ? TargetBase + ImmExt :
                  PCSrc == 2'b10 ? {ALUResult[31:1], 1'b0} : TRAP_VEC;
  assign next_pc = Redirect ? target : take ? pc + 32'd4 : pc;
  // a fresh request begins whenever we (re)enter FETCH or finish one while staying there
  assign start = next_state == FETCH && (state != FETCH || ack);
  assign PCPlus4 = PCOut + 32'd4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = Redirect || state == IDLE ? FETCH :
                 state == FETCH ? (take && !slot_free ? FULL : FETCH) :
                 (Stall ? FULL : FETCH);
  end
  always_comb begin
    imem.ImemReq = state == FETCH;
    imem.ImemAddr = req_addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      squash <= 1'b0;
      skid_instr <= '0;
      skid_pc <= '0;
      InstrValid <= 1'b0;
      Instr <= 32'h0000_0013;
      PCOut <= RESET_PC;
    end else begin
      pc <= next_pc;
      squash <= state == FETCH && !imem.ImemAck && (squash || Redirect);
      if (start) req_addr <= next_pc;
      if (Redirect) begin
        InstrValid <= 1'b0;
        skid_instr <= '0;
        skid_pc <= '0;
      end else if (take && slot_free) begin
        Instr <= imem.ImemRData;
        PCOut <= req_addr;
        InstrValid <= 1'b1;
      end else if (take) begin
        skid_instr <= imem.ImemRData;
        skid_pc <= req_addr;
      end else if (state == FULL && !Stall) begin
        Instr <= skid_instr;
        PCOut <= skid_pc;
        skid_instr <= '0;
        skid_pc <= '0;
      end else if (!Stall) InstrValid <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenario tasks for fetch_stage with inline checks
module tb_fetch_stage;
  logic clk = 0, rst_n = 1, Redirect = 0, Stall = 0;
  logic [1:0] PCSrc = 0;
  logic [31:0] TargetBase = 0, ImmExt = 0, ALUResult = 0;
  logic InstrValid;
  logic [31:0] Instr, PCOut, PCPlus4;
  int errors = 0, checks = 0;
  fetch_stage_if imem();
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .Redirect(Redirect), .PCSrc(PCSrc),
    .TargetBase(TargetBase), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .Stall(Stall), .imem(imem), .InstrValid(InstrValid), .Instr(Instr),
    .PCOut(PCOut), .PCPlus4(PCPlus4)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_ack(input logic a);
    imem.ImemAck = a;
    imem.ImemRData = word(imem.ImemAddr);
  endtask
  task automatic do_reset;
    Redirect = 0; Stall = 0; PCSrc = 0; imem.ImemAck = 0; imem.ImemRData = 0;
    rst_n = 0;
    step;
    rst_n = 1;
    step;
  endtask
  task automatic test_reset;
    imem.ImemAck = 0; imem.ImemRData = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (imem.ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem.ImemReq); end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", InstrValid); end
    checks++; if (Instr !== 32'h13) begin errors++; $display("FAIL rst_instr got %h want 00000013", Instr); end
    checks++; if (PCOut !== 32'h0) begin errors++; $display("FAIL rst_pcout got %h want 0", PCOut); end
    checks++; if (PCPlus4 !== 32'h4) begin errors++; $display("FAIL rst_pcplus4 got %h want 4", PCPlus4); end
    step;
    rst_n = 1;
    #1;
    checks++; if (imem.ImemReq !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", imem.ImemReq); end
    step;
    checks++; if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h want 1/0", imem.ImemReq, imem.ImemAddr); end
  endtask
  task automatic test_stream;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive_ack(1);
      step;
      checks++; if (InstrValid !== 1'b1 || Instr !== word(32'(4 * i)) || PCOut !== 32'(4 * i)) begin errors++; $display("FAIL stream%0d got v=%b %h@%h want 1 %h@%h", i, InstrValid, Instr, PCOut, word(32'(4 * i)), 4 * i); end
      checks++; if (imem.ImemAddr !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_addr%0d got %h want %h", i, imem.ImemAddr, 4 * i + 4); end
    end
    drive_ack(0);
    step;
    checks++; if (InstrValid !== 1'b0 || imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'hC) begin errors++; $display("FAIL stream_drain got v=%b req=%b %h want 0 1 0000000c", InstrValid, imem.ImemReq, imem.ImemAddr); end
  endtask
  task automatic test_stall;
    do_reset;
    drive_ack(1);
    step;
    Stall = 1;
    drive_ack(1);
    step;
    checks++; if (imem.ImemReq !== 1'b0 || Instr !== word(0) || PCOut !== 0 || InstrValid !== 1) begin errors++; $display("FAIL stall_full got req=%b %h@%h v=%b want 0 %h@0 1", imem.ImemReq, Instr, PCOut, InstrValid, word(0)); end
    drive_ack(0);
    step;
    checks++; if (imem.ImemReq !== 1'b0 || Instr !== word(0)) begin errors++; $display("FAIL stall_hold got req=%b %h want 0 %h", imem.ImemReq, Instr, word(0)); end
    Stall = 0;
    step;
    checks++; if (InstrValid !== 1 || Instr !== word(4) || PCOut !== 32'h4) begin errors++; $display("FAIL stall_skid got v=%b %h@%h want 1 %h@4", InstrValid, Instr, PCOut, word(4)); end
    checks++; if (imem.ImemReq !== 1 || imem.ImemAddr !== 32'h8) begin errors++; $display("FAIL stall_resume got %b/%h want 1/8", imem.ImemReq, imem.ImemAddr); end
    step;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL stall_consume got %b want 0", InstrValid); end
  endtask
  task automatic test_redirect_full;
    do_reset;
    drive_ack(1);
    step;
    Stall = 1;
    drive_ack(1);
    step;
    drive_ack(0);
    Redirect = 1; PCSrc = 2'b11;
    step;
    Redirect = 0; Stall = 0;
    checks++; if (InstrValid !== 0 || imem.ImemReq !== 1 || imem.ImemAddr !== 32'h4) begin errors++; $display("FAIL redir_full got v=%b req=%b %h want 0 1 00000004", InstrValid, imem.ImemReq, imem.ImemAddr); end
  endtask
  task automatic test_redirect_squash;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      drive_ack(1);
      step;
    end
    checks++; if (imem.ImemAddr !== 32'h20) begin errors++; $display("FAIL squash_pre got %h want 00000020", imem.ImemAddr); end
    drive_ack(0);
    Redirect = 1; PCSrc = 2'b01; TargetBase = 32'h10; ImmExt = 32'hFFFF_FFF8;
    step;
    Redirect = 0;
    checks++; if (InstrValid !== 0 || imem.ImemReq !== 1 || imem.ImemAddr !== 32'h20) begin errors++; $display("FAIL squash_hold got v=%b req=%b %h want 0 1 00000020", InstrValid, imem.ImemReq, imem.ImemAddr); end
    step;
    checks++; if (InstrValid !== 0 || imem.ImemAddr !== 32'h20) begin errors++; $display("FAIL squash_wait got v=%b %h want 0 00000020", InstrValid, imem.ImemAddr); end
    drive_ack(1);
    step;
    checks++; if (InstrValid !== 0 || imem.ImemAddr !== 32'h8) begin errors++; $display("FAIL squash_drop got v=%b %h want 0 00000008", InstrValid, imem.ImemAddr); end
    drive_ack(1);
    step;
    checks++; if (InstrValid !== 1 || Instr !== word(8) || PCOut !== 32'h8) begin errors++; $display("FAIL squash_new got v=%b %h@%h want 1 %h@8", InstrValid, Instr, PCOut, word(8)); end
  endtask
  task automatic test_redirect_ack;
    Redirect = 1; PCSrc = 2'b10; ALUResult = 32'h103;
    drive_ack(1);
    step;
    Redirect = 0;
    checks++; if (InstrValid !== 0 || imem.ImemAddr !== 32'h102) begin errors++; $display("FAIL jalr_ack got v=%b %h want 0 00000102", InstrValid, imem.ImemAddr); end
    Redirect = 1; PCSrc = 2'b11;
    drive_ack(0);
    step;
    Redirect = 0;
    checks++; if (imem.ImemAddr !== 32'h102 || InstrValid !== 0) begin errors++; $display("FAIL trap_hold got %h v=%b want 00000102 0", imem.ImemAddr, InstrValid); end
    drive_ack(1);
    step;
    checks++; if (imem.ImemAddr !== 32'h4 || InstrValid !== 0) begin errors++; $display("FAIL trap_vec got %h v=%b want 00000004 0", imem.ImemAddr, InstrValid); end
    Redirect = 1; PCSrc = 2'b00;
    drive_ack(1);
    step;
    Redirect = 0;
    checks++; if (imem.ImemAddr !== 32'h8 || InstrValid !== 0) begin errors++; $display("FAIL seq_redir got %h v=%b want 00000008 0", imem.ImemAddr, InstrValid); end
  endtask
  task automatic test_wrap;
    Redirect = 1; PCSrc = 2'b10; ALUResult = 32'hFFFF_FFFC;
    drive_ack(1);
    step;
    Redirect = 0;
    checks++; if (imem.ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %h want fffffffc", imem.ImemAddr); end
    drive_ack(1);
    step;
    checks++; if (InstrValid !== 1 || PCOut !== 32'hFFFF_FFFC || Instr !== word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr got v=%b %h@%h want 1 %h@fffffffc", InstrValid, Instr, PCOut, word(32'hFFFF_FFFC)); end
    checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got %h want 0", PCPlus4); end
    checks++; if (imem.ImemAddr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", imem.ImemAddr); end
    drive_ack(0);
  endtask
  task automatic test_reset_mid;
    Redirect = 1; PCSrc = 2'b11;
    step;
    Redirect = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (imem.ImemReq !== 0 || InstrValid !== 0 || Instr !== 32'h13) begin errors++; $display("FAIL mid_rst got req=%b v=%b %h want 0 0 00000013", imem.ImemReq, InstrValid, Instr); end
    checks++; if (PCOut !== 32'h0 || PCPlus4 !== 32'h4) begin errors++; $display("FAIL mid_rst_pc got %h/%h want 0/4", PCOut, PCPlus4); end
    imem.ImemAck = 1; imem.ImemRData = 32'hDEAD_BEEF;
    step;
    rst_n = 1;
    #1;
    checks++; if (imem.ImemReq !== 0) begin errors++; $display("FAIL late_ack_idle got %b want 0", imem.ImemReq); end
    step;
    checks++; if (imem.ImemReq !== 1 || imem.ImemAddr !== 32'h0 || InstrValid !== 0) begin errors++; $display("FAIL late_ack_ign got req=%b %h v=%b want 1 0 0", imem.ImemReq, imem.ImemAddr, InstrValid); end
    drive_ack(1);
    step;
    checks++; if (InstrValid !== 1 || Instr !== word(0) || PCOut !== 0) begin errors++; $display("FAIL post_rst got v=%b %h@%h want 1 %h@0", InstrValid, Instr, PCOut, word(0)); end
    drive_ack(0);
  endtask
  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect_full;
    test_redirect_squash;
    test_redirect_ack;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0004: redirect target selected by PCSrc=2'b11.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port Redirect  input  1  execute-stage request to change flow this cycle.
REQ-006 The block SHALL have port PCSrc  input  2  redirect target select, qualified by Redirect.
REQ-007 The block SHALL have port TargetBase  input  32  PC of the redirecting instruction.
REQ-008 The block SHALL have port ImmExt  input  32  sign-extended immediate from the immediate extender.
REQ-009 The block SHALL have port ALUResult  input  32  register-indirect target (JALR).
REQ-010 The block SHALL have port Stall  input  1  decode back-pressure; output slot not consumed while high.
REQ-011 The block SHALL have port ImemReq  output  1  instruction memory request.
REQ-012 The block SHALL have port ImemAddr  output  32  request address.
REQ-013 The block SHALL have port ImemAck  input  1  one-cycle response strobe; meaningful only while ImemReq=1.
REQ-014 The block SHALL have port ImemRData  input  32  instruction word, valid with ImemAck.
REQ-015 The block SHALL have port InstrValid  output  1  output slot holds a valid instruction.
REQ-016 The block SHALL have port Instr  output  32  instruction to decode (feeds imm[31:7] of the extender).
REQ-017 The block SHALL have port PCOut  output  32  address of Instr.
REQ-018 The block SHALL have port PCPlus4  output  32  PCOut+4 modulo 2^32.

Function
REQ-019 The block SHALL implement states IDLE, FETCH, FULL; IDLE->FETCH unconditionally after one cycle.
REQ-020 In FETCH, the block SHALL assert ImemReq=1 with ImemAddr=ReqAddr, holding both stable until the ImemAck cycle; ImemReq=0 in IDLE and FULL.
REQ-021 ReqAddr SHALL be loaded from PC when a new request starts; PC SHALL advance by 4 (mod 2^32, FFFF_FFFC->0) on each accepted, non-squashed ack.
REQ-022 The output slot SHALL be free in a cycle where InstrValid=0 or Stall=0; consumption occurs on InstrValid=1 and Stall=0.
REQ-023 On accepted ack with slot free: Instr<=ImemRData, PCOut<=ReqAddr, InstrValid<=1, remain in FETCH (back-to-back requests, 1 instr per ack).
REQ-024 On accepted ack with slot not free: word and address SHALL be captured in a one-entry skid register and the state SHALL go to FULL.
REQ-025 In FULL with Stall=0: output slot<=skid contents, skid cleared, ->FETCH; with Stall=1 state and outputs SHALL hold.
REQ-026 A consumption with no ack in the same cycle SHALL clear InstrValid next cycle.
REQ-027 Redirect target: PCSrc 2'b00 -> PC+4 (no change of flow); 2'b01 -> TargetBase+ImmExt (32-bit wrap); 2'b10 -> {ALUResult[31:1],1'b0}; 2'b11 -> TRAP_VEC.
REQ-028 Redirect=1 SHALL have highest priority over Stall and ack: PC<=target, InstrValid<=0, skid cleared, next state FETCH.
REQ-029 Redirect while a request is outstanding and ImemAck=0 SHALL set a squash flag; the outstanding request SHALL complete at its old address and its data SHALL be discarded, then the next request SHALL use the new PC.
REQ-030 Redirect in the same cycle as ImemAck SHALL discard that data without setting squash.
REQ-031 PCPlus4 SHALL be combinational from PCOut.

Reset
REQ-032 While rst_n=0, regardless of clk: PC=RESET_PC, state IDLE, ImemReq=0, InstrValid=0, squash=0, skid empty, Instr=32'h0000_0013, PCOut=RESET_PC.
REQ-033 Reset asserted mid-request SHALL abandon the request; a late ImemAck after release and before the first request SHALL be ignored.

Verification
REQ-034 Reset release, ImemAck every cycle after req, Stall=0, words A,B,C -> Instr A@0,B@4,C@8 on consecutive cycles after first ack.
REQ-035 Instr A held by Stall=1, ack for B arrives -> FULL, ImemReq=0, A held; Stall=0 -> B@4 shown next cycle, fetch resumes at 8.
REQ-036 Redirect PCSrc=01, TargetBase=0x10, ImmExt=0xFFFF_FFF8 while request at 0x20 pending -> that ack discarded, next ImemAddr=0x08, InstrValid=0 meanwhile.
REQ-037 Redirect PCSrc=10, ALUResult=0x0000_0103, coincident with ack -> data dropped, next ImemAddr=0x102; PCSrc=11 -> TRAP_VEC.
REQ-038 PC=0xFFFF_FFFC fetched -> PCPlus4=0, next ImemAddr=0.
REQ-039 rst_n pulsed low mid-wait -> all outputs at REQ-032 values immediately; first request after release at RESET_PC.
